// File: rtl/vscale_mp_hasti_sram_pkg.sv
// -----------------------------------------------------------------------------
// vscale_mp_hasti_sram_pkg
// Shared definitions for the multi-port HASTI SRAM model:
//   - per-port FSM state encoding (IDLE/DATA/ERR1/ERR2)
//   - HASTI transfer-size codes
//   - byte-lane mask lookup used when capturing an address phase
// Optional feature macro: VSCALE_SRAM_ERR_RESP_EN (ERR1/ERR2 only reachable
// when it is defined).
// -----------------------------------------------------------------------------
package vscale_mp_hasti_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Lane pattern for a naturally aligned access of the given size.
    // Anything wider than a word is treated as a word.
    function automatic logic [3:0] size_lut(input logic [2:0] hsize);
        case (hsize)
            HSIZE_BYTE: return 4'h1;
            HSIZE_HALF: return 4'h3;
            HSIZE_WORD: return 4'hf;
            default:    return 4'hf;
        endcase
    endfunction

    // Lanes touched by an access; a misaligned access is clipped at the
    // word boundary rather than spilling into the next word.
    function automatic logic [3:0] byte_mask(input logic [2:0] hsize,
                                             input logic [1:0] lsb);
        logic [3:0] lut;
        lut = size_lut(hsize);
        return lut << lsb;
    endfunction

endpackage

// File: rtl/vscale_mp_hasti_sram_port.sv
// -----------------------------------------------------------------------------
// vscale_mp_hasti_sram_port
// One HASTI slave port of the multi-port SRAM. Captures the address phase
// (word, lane mask, write flag), runs the per-port FSM, drives hready/hresp
// and holds the registered read data. Write data is not stored: it is passed
// straight through as a commit request during the data phase and the top
// applies it to the memory at the edge ending that phase.
// Ports:
//   hclk, hresetn            clock, async active-low reset
//   haddr/hwrite/hsize/htrans address-phase inputs of this port
//   hwdata                   data-phase write data
//   rd_data                  memory word at addr_word with same-edge writes merged
//   addr_word                word index of the current address phase
//   hrdata/hready/hresp      HASTI responses
//   commit_*                 write to apply at the coming edge
// Optional feature macro: VSCALE_SRAM_ERR_RESP_EN (error responses).
// -----------------------------------------------------------------------------
module vscale_mp_hasti_sram_port
    import vscale_mp_hasti_sram_pkg::*;
#(
    parameter int NWORDS = 65536,
    parameter int AW     = $clog2(NWORDS)
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic [31:0]   haddr,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [1:0]    htrans,
    input  logic [31:0]   hwdata,
    input  logic [31:0]   rd_data,
    output logic [AW-1:0] addr_word,
    output logic [31:0]   hrdata,
    output logic          hready,
    output logic          hresp,
    output logic          commit_vld,
    output logic [AW-1:0] commit_word,
    output logic [3:0]    commit_mask,
    output logic [31:0]   commit_wdata
);

    state_e        state_q, state_d;
    logic [AW-1:0] word_q, word_d;
    logic [3:0]    mask_q, mask_d;
    logic          write_q, write_d;
    logic [31:0]   hrdata_q, hrdata_d;
    logic          accept;
    logic          bad_access;
    logic          unused_htrans0;

    // htrans[1] alone separates NONSEQ/SEQ from IDLE/BUSY.
    assign unused_htrans0 = htrans[0];

    assign addr_word = AW'(32'(haddr[31:2]) % 32'(NWORDS));

`ifdef VSCALE_SRAM_ERR_RESP_EN
    assign hready = (state_q != ST_ERR1);
    assign hresp  = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
    assign hready = 1'b1;
    assign hresp  = 1'b0;
`endif

    assign accept = hready && htrans[1];

    always_comb begin
        bad_access = 1'b0;
`ifdef VSCALE_SRAM_ERR_RESP_EN
        bad_access = ({1'b0, haddr} >= (33'(NWORDS) * 33'd4))
                  || (hsize > HSIZE_WORD)
                  || ((hsize == HSIZE_HALF) && haddr[0])
                  || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
`endif
    end

    always_comb begin
        state_d  = ST_IDLE;
        word_d   = word_q;
        mask_d   = mask_q;
        write_d  = 1'b0;
        hrdata_d = hrdata_q;
        if (accept) begin
            if (bad_access) begin
                state_d = ST_ERR1;
            end else begin
                state_d = ST_DATA;
                word_d  = addr_word;
                mask_d  = byte_mask(hsize, haddr[1:0]);
                write_d = hwrite;
                // Read data is captured at the end of the address phase so it
                // is valid for the whole data phase.
                if (!hwrite) begin
                    hrdata_d = rd_data;
                end
            end
        end
`ifdef VSCALE_SRAM_ERR_RESP_EN
        else if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end
`endif
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            mask_q   <= '0;
            write_q  <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            mask_q   <= mask_d;
            write_q  <= write_d;
            hrdata_q <= hrdata_d;
        end
    end

    assign hrdata       = hrdata_q;
    assign commit_vld   = (state_q == ST_DATA) && write_q;
    assign commit_word  = word_q;
    assign commit_mask  = mask_q;
    assign commit_wdata = hwdata;

endmodule

// File: rtl/vscale_mp_hasti_sram.sv
// -----------------------------------------------------------------------------
// vscale_mp_hasti_sram
// Multi-port HASTI SRAM model for the vscale harness. NPORTS independent
// slave ports share one NWORDS x 32 memory. Writes commit at the edge ending
// their data phase; reads sample at the edge ending their address phase and
// see every write committing at that same edge (per-byte forwarding). When
// several ports write the same byte in one cycle the highest port index wins.
// Ports (port i occupies slice i of each vector):
//   hclk, hresetn                          clock, async active-low reset
//   haddr[32*i+:32], hwrite[i], hsize[3*i+:3], htrans[2*i+:2]  address phase
//   hburst, hmastlock, hprot               accepted but ignored
//   hwdata[32*i+:32]                       write data (data phase)
//   hrdata[32*i+:32], hready[i], hresp[i]  responses
// Optional feature macro: VSCALE_SRAM_ERR_RESP_EN (error responses for
// out-of-range, oversized or misaligned transfers).
// -----------------------------------------------------------------------------
module vscale_mp_hasti_sram
    import vscale_mp_hasti_sram_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int NWORDS = 65536
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic [NPORTS*32-1:0] haddr,
    input  logic [NPORTS-1:0]    hwrite,
    input  logic [NPORTS*3-1:0]  hsize,
    input  logic [NPORTS*3-1:0]  hburst,
    input  logic [NPORTS-1:0]    hmastlock,
    input  logic [NPORTS*4-1:0]  hprot,
    input  logic [NPORTS*2-1:0]  htrans,
    input  logic [NPORTS*32-1:0] hwdata,
    output logic [NPORTS*32-1:0] hrdata,
    output logic [NPORTS-1:0]    hready,
    output logic [NPORTS-1:0]    hresp
);

    localparam int AW = $clog2(NWORDS);

    logic [31:0]   mem [NWORDS];
    logic [AW-1:0] addr_word    [NPORTS];
    logic [31:0]   rd_data      [NPORTS];
    logic [NPORTS-1:0] commit_vld;
    logic [AW-1:0] commit_word  [NPORTS];
    logic [3:0]    commit_mask  [NPORTS];
    logic [31:0]   commit_wdata [NPORTS];
    logic          unused_inputs;

    assign unused_inputs = ^{hburst, hmastlock, hprot};

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        vscale_mp_hasti_sram_port #(
            .NWORDS(NWORDS),
            .AW    (AW)
        ) u_port (
            .hclk        (hclk),
            .hresetn     (hresetn),
            .haddr       (haddr[32*i +: 32]),
            .hwrite      (hwrite[i]),
            .hsize       (hsize[3*i +: 3]),
            .htrans      (htrans[2*i +: 2]),
            .hwdata      (hwdata[32*i +: 32]),
            .rd_data     (rd_data[i]),
            .addr_word   (addr_word[i]),
            .hrdata      (hrdata[32*i +: 32]),
            .hready      (hready[i]),
            .hresp       (hresp[i]),
            .commit_vld  (commit_vld[i]),
            .commit_word (commit_word[i]),
            .commit_mask (commit_mask[i]),
            .commit_wdata(commit_wdata[i])
        );
    end

    // Ports are applied in ascending order so the last (highest-index)
    // assignment to a byte is the one that sticks.
    always_ff @(posedge hclk) begin
        for (int p = 0; p < NPORTS; p++) begin
            for (int b = 0; b < 4; b++) begin
                if (hresetn && commit_vld[p] && commit_mask[p][b]) begin
                    mem[commit_word[p]][8*b +: 8] <= commit_wdata[p][8*b +: 8];
                end
            end
        end
    end

    // Read data as the memory will look after this edge's commits, using the
    // same ascending-port priority as the write path.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            rd_data[i] = mem[addr_word[i]];
            for (int j = 0; j < NPORTS; j++) begin
                for (int b = 0; b < 4; b++) begin
                    if (commit_vld[j] && commit_mask[j][b] &&
                        (commit_word[j] == addr_word[i])) begin
                        rd_data[i][8*b +: 8] = commit_wdata[j][8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vscale_mp_hasti_sram.sv
module tb_vscale_mp_hasti_sram;

    localparam int NP = 2;
    localparam int NW = 256;

    logic          hclk;
    logic          hresetn;
    logic [63:0]   haddr;
    logic [1:0]    hwrite;
    logic [5:0]    hsize;
    logic [5:0]    hburst;
    logic [1:0]    hmastlock;
    logic [7:0]    hprot;
    logic [3:0]    htrans;
    logic [63:0]   hwdata;
    logic [63:0]   hrdata;
    logic [1:0]    hready;
    logic [1:0]    hresp;

    vscale_mp_hasti_sram #(.NPORTS(NP), .NWORDS(NW)) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .haddr    (haddr),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hburst   (hburst),
        .hmastlock(hmastlock),
        .hprot    (hprot),
        .htrans   (htrans),
        .hwdata   (hwdata),
        .hrdata   (hrdata),
        .hready   (hready),
        .hresp    (hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Reference model: memory image plus the outstanding data phase per port.
    logic [31:0] mem_m [NW];
    bit          pv    [NP];
    bit          pw    [NP];
    int          pword [NP];
    logic [3:0]  pmask [NP];
    logic [31:0] exp_rd[NP];

    int n_pass;
    int n_total;

    typedef struct {
        logic [31:0] waddr;
        int          wsize;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];
    int   n_tbl;

    function automatic logic [31:0] ival(input int i);
        return 32'h5A5A5A5A ^ (32'(i) * 32'h01030507);
    endfunction

    function automatic bit is_bad(input logic [31:0] a, input int sz);
`ifdef VSCALE_SRAM_ERR_RESP_EN
        return (a >= 32'(NW * 4)) || (sz > 2) || (sz == 1 && a[0]) ||
               (sz == 2 && a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic issue(input int p, input logic [1:0] tr, input bit wr,
                         input int sz, input logic [31:0] a);
        htrans[2*p +: 2] = tr;
        hwrite[p]        = wr;
        hsize[3*p +: 3]  = 3'(sz);
        haddr[32*p +: 32] = a;
    endtask

    task automatic setw(input int p, input logic [31:0] d);
        hwdata[32*p +: 32] = d;
    endtask

    task automatic idle_all();
        for (int p = 0; p < NP; p++) issue(p, 2'b00, 1'b0, 2, 32'h0);
    endtask

    // Advance one clock: update the model from the inputs currently driven,
    // then compare every port after the edge.
    task automatic step(input bit chk_hs);
        for (int p = 0; p < NP; p++) begin
            if (pv[p] && pw[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (pmask[p][b]) mem_m[pword[p]][8*b +: 8] = hwdata[32*p + 8*b +: 8];
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            logic [31:0] a;
            int sz, nb, m;
            a  = haddr[32*p +: 32];
            sz = int'(hsize[3*p +: 3]);
            if (htrans[2*p + 1] && !is_bad(a, sz)) begin
                nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
                m  = ((1 << nb) - 1) << (a % 4);
                pmask[p] = 4'(m);
                pword[p] = int'((a >> 2) % NW);
                pv[p]    = 1'b1;
                pw[p]    = hwrite[p];
                if (!pw[p]) exp_rd[p] = mem_m[pword[p]];
            end else begin
                pv[p] = 1'b0;
            end
        end
        @(posedge hclk);
        #1;
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("p%0d_hrdata", p), hrdata[32*p +: 32], exp_rd[p]);
            if (chk_hs) begin
                chk($sformatf("p%0d_hready", p), {31'b0, hready[p]}, 32'd1);
                chk($sformatf("p%0d_hresp", p),  {31'b0, hresp[p]},  32'd0);
            end
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        hresetn = 1'b0;
        haddr = '0; hwrite = '0; hsize = '0; hburst = '0; hmastlock = '0;
        hprot = '0; htrans = '0; hwdata = '0;
        for (int p = 0; p < NP; p++) begin
            pv[p] = 1'b0; pw[p] = 1'b0; pword[p] = 0; pmask[p] = '0; exp_rd[p] = '0;
        end
        for (int i = 0; i < NW; i++) mem_m[i] = '0;

        // Reset state
        repeat (2) @(posedge hclk);
        #1;
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("rst_hready%0d", p), {31'b0, hready[p]}, 32'd1);
            chk($sformatf("rst_hresp%0d", p),  {31'b0, hresp[p]},  32'd0);
            chk($sformatf("rst_hrdata%0d", p), hrdata[32*p +: 32], 32'h0);
        end
        hresetn = 1'b1;

        // Fill words 0..63 with known values (back-to-back writes)
        for (int i = 0; i < 64; i++) begin
            issue(0, 2'b10, 1'b1, 2, 32'(i * 4));
            setw(0, (i == 0) ? 32'h0 : ival(i - 1));
            step(1);
        end
        idle_all();
        setw(0, ival(63));
        step(1);

        // Table: prime 0x100 with 0x11223344, sub-word write, read back
        n_tbl = 0;
        tbl[n_tbl++] = '{32'h101, 0, 32'hAAAAAAAA, 32'h1122AA44};
        tbl[n_tbl++] = '{32'h100, 0, 32'hCCCCCCCC, 32'h112233CC};
        tbl[n_tbl++] = '{32'h103, 0, 32'h77777777, 32'h77223344};
        tbl[n_tbl++] = '{32'h102, 1, 32'hBEEFBEEF, 32'hBEEF3344};
        tbl[n_tbl++] = '{32'h100, 1, 32'hBEEFBEEF, 32'h1122BEEF};
        tbl[n_tbl++] = '{32'h100, 2, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[n_tbl++] = '{32'h102, 0, 32'h12345678, 32'h11343344};
`ifndef VSCALE_SRAM_ERR_RESP_EN
        tbl[n_tbl++] = '{32'h103, 1, 32'h55667788, 32'h55223344};
        tbl[n_tbl++] = '{32'h102, 2, 32'h99887766, 32'h99883344};
        tbl[n_tbl++] = '{32'h100, 3, 32'h0BADF00D, 32'h0BADF00D};
`endif
        for (int k = 0; k < n_tbl; k++) begin
            issue(0, 2'b10, 1'b1, 2, 32'h100);
            step(1);
            setw(0, 32'h11223344);
            issue(0, 2'b10, 1'b1, tbl[k].wsize, tbl[k].waddr);
            step(1);
            setw(0, tbl[k].wdata);
            issue(0, 2'b10, 1'b0, 2, 32'h100);
            step(1);
            chk($sformatf("tbl_%0d", k), hrdata[31:0], tbl[k].exp);
            idle_all();
            step(1);
        end

        // Forwarding: p1 reads the word p0 is writing in the same cycle
        issue(0, 2'b10, 1'b1, 2, 32'h40);
        step(1);
        setw(0, 32'hDEADBEEF);
        issue(0, 2'b00, 1'b0, 2, 32'h0);
        issue(1, 2'b10, 1'b0, 2, 32'h40);
        step(1);
        chk("fwd_p1_data", hrdata[63:32], 32'hDEADBEEF);
        chk("fwd_p1_ready", {31'b0, hready[1]}, 32'd1);
        idle_all();
        step(1);

        // Collision: same word written by both ports, p1 wins upper half
        issue(0, 2'b10, 1'b1, 2, 32'h80);
        issue(1, 2'b10, 1'b1, 1, 32'h82);
        step(1);
        setw(0, 32'h11111111);
        setw(1, 32'h22222222);
        idle_all();
        step(1);
        issue(0, 2'b10, 1'b0, 2, 32'h80);
        step(1);
        chk("collision", hrdata[31:0], 32'h22221111);
        idle_all();
        step(1);

        // Throughput: 16 back-to-back SEQ word reads
        for (int i = 0; i < 16; i++) begin
            issue(0, (i == 0) ? 2'b10 : 2'b11, 1'b0, 2, 32'(i * 4));
            step(1);
            chk($sformatf("thru_%0d", i), hrdata[31:0], ival(i));
            chk($sformatf("thru_rdy_%0d", i), {31'b0, hready[0]}, 32'd1);
        end
        idle_all();
        step(1);

        // Access one past the end of memory
`ifdef VSCALE_SRAM_ERR_RESP_EN
        issue(0, 2'b10, 1'b0, 2, 32'(NW * 4));
        step(0);
        chk("err1_ready", {31'b0, hready[0]}, 32'd0);
        chk("err1_resp",  {31'b0, hresp[0]},  32'd1);
        idle_all();
        step(0);
        chk("err2_ready", {31'b0, hready[0]}, 32'd1);
        chk("err2_resp",  {31'b0, hresp[0]},  32'd1);
        issue(0, 2'b10, 1'b1, 2, 32'(NW * 4));
        step(0);
        setw(0, 32'hFFFFFFFF);
        idle_all();
        step(0);
        step(0);
        issue(0, 2'b10, 1'b0, 2, 32'h0);
        step(1);
        chk("err_mem0", hrdata[31:0], ival(0));
`else
        issue(0, 2'b10, 1'b0, 2, 32'(NW * 4));
        step(1);
        chk("wrap_rd", hrdata[31:0], ival(0));
        chk("wrap_resp", {31'b0, hresp[0]}, 32'd0);
`endif
        idle_all();
        step(1);

        // Reset during the data phase of a write to 0x10
        issue(0, 2'b10, 1'b1, 2, 32'h10);
        step(1);
        setw(0, 32'hFFFFFFFF);
        idle_all();
        #1;
        hresetn = 1'b0;
        for (int p = 0; p < NP; p++) begin
            pv[p] = 1'b0;
            exp_rd[p] = '0;
        end
        @(posedge hclk);
        #1;
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("mid_rst_hready%0d", p), {31'b0, hready[p]}, 32'd1);
            chk($sformatf("mid_rst_hresp%0d", p),  {31'b0, hresp[p]},  32'd0);
            chk($sformatf("mid_rst_hrdata%0d", p), hrdata[32*p +: 32], 32'h0);
        end
        #1;
        hresetn = 1'b1;
        issue(0, 2'b10, 1'b0, 2, 32'h10);
        step(1);
        chk("mid_rst_mem4", hrdata[31:0], ival(4));
        idle_all();
        step(1);

        // Randomised traffic on both ports over a small window
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom % 10 < 7) begin
                    int sz;
                    logic [31:0] a;
`ifdef VSCALE_SRAM_ERR_RESP_EN
                    sz = int'($urandom % 3);
                    a  = $urandom % 256;
                    if (sz == 1) a = a & ~32'h1;
                    if (sz == 2) a = a & ~32'h3;
`else
                    sz = int'($urandom % 4);
                    a  = $urandom % 256;
`endif
                    issue(p, ($urandom % 2) ? 2'b11 : 2'b10, 1'($urandom % 2), sz, a);
                end else begin
                    issue(p, 2'($urandom % 2), 1'b0, 2, $urandom % 256);
                end
                setw(p, $urandom);
            end
            step(1);
        end
        idle_all();
        step(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
